dmem_arbiter: RTL

- Two-port arbiter/sequencer that shares one single-port synchronous data memory between two requesters.
- Port 0 is the CPU load/store port (addr/writedata/memwrite/readdata). Port 1 is a secondary master (loader/debug DMA).
- Selects one requester per transaction, drives the memory for exactly one cycle, waits the memory read latency, then returns a one-cycle ack with the read data.

---
 rtl/dmem_arbiter_if.sv | 65 ++++++
 rtl/dmem_arbiter.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter_if.sv
// -----------------------------------------------------------------------------
// dmem_arbiter_if
//   Bundle of every bus signal around the data-memory arbiter: the two
//   requester ports (m0 = CPU load/store, m1 = loader/debug DMA), the shared
//   single-port memory, and the busy/grant status outputs.
//
//   Modports:
//     slave  - arbiter view: takes requests and mem_rdata, drives acks, read
//              data, the memory strobe/address/data and status.
//     master - environment view: drives requests and mem_rdata, observes
//              everything else.
//
//   Parameters: AW (address width), DW (data width).
// -----------------------------------------------------------------------------
interface dmem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  // Port 0 (CPU)
  logic          m0_req;
  logic          m0_we;
  logic [AW-1:0] m0_addr;
  logic [DW-1:0] m0_wdata;
  logic          m0_ack;
  logic [DW-1:0] m0_rdata;

  // Port 1 (loader / debug DMA)
  logic          m1_req;
  logic          m1_we;
  logic [AW-1:0] m1_addr;
  logic [DW-1:0] m1_wdata;
  logic          m1_ack;
  logic [DW-1:0] m1_rdata;

  // Shared single-port memory
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  // Status
  logic          busy;
  logic          gnt_id;

  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wdata,
    input  m1_req, m1_we, m1_addr, m1_wdata,
    input  mem_rdata,
    output m0_ack, m0_rdata,
    output m1_ack, m1_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    output busy, gnt_id
  );

  modport master (
    output m0_req, m0_we, m0_addr, m0_wdata,
    output m1_req, m1_we, m1_addr, m1_wdata,
    output mem_rdata,
    input  m0_ack, m0_rdata,
    input  m1_ack, m1_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    input  busy, gnt_id
  );
endinterface

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//   Shares one single-port synchronous data memory between two requesters.
//   One requester is selected per transaction (only while idle), the memory is
//   strobed for exactly one cycle from captured request registers, the read
//   latency is waited out, and a one-cycle ack is returned to the granted port
//   with the memory read data passed straight through.
//
//   Timing (request sampled in cycle T0):
//     mem_en in T1; write ack in T2; read ack in T1+RD_LAT.
//
//   Ports:
//     clk    - system clock, rising edge
//     rstn   - synchronous active-low reset; drops any in-flight transaction
//     bus    - dmem_arbiter_if.slave: m0_*/m1_* requester handshakes,
//              mem_* memory interface, busy and gnt_id status
//
//   Parameters:
//     AW     - address width
//     DW     - data width
//     RD_LAT - memory read latency, mem_en to valid mem_rdata (1..8)
//
//   Build option:
//     DMEM_ARB_RR_EN - when defined, ties are broken round-robin (the port not
//                      granted last wins; port 0 wins the first tie after
//                      reset). When undefined, port 0 always wins ties.
// -----------------------------------------------------------------------------
module dmem_arbiter #(
  parameter int AW     = 32,
  parameter int DW     = 32,
  parameter int RD_LAT = 1
) (
  input  logic           clk,
  input  logic           rstn,
  dmem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  // WAIT exits when the counter is already 0, so loading RD_LAT-2 yields
  // RD_LAT-1 WAIT cycles and places RESP exactly RD_LAT cycles after ISSUE.
  localparam logic [2:0] CNT_INIT = (RD_LAT > 1) ? 3'(RD_LAT - 2) : 3'd0;

  state_t        state_q, state_d;
  logic [2:0]    cnt_q, cnt_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          gnt_q, gnt_d;
`ifdef DMEM_ARB_RR_EN
  logic          last_q, last_d;
`endif

  logic          any_req;
  logic          pick;
  logic          in_issue;
  logic          in_resp;

  // Arbitration: pick is the winning port, meaningful only when any_req.
  always_comb begin
    any_req = bus.m0_req | bus.m1_req;
`ifdef DMEM_ARB_RR_EN
    if (bus.m0_req && bus.m1_req) begin
      pick = ~last_q;
    end else begin
      pick = ~bus.m0_req;
    end
`else
    pick = ~bus.m0_req;
`endif
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    gnt_d   = gnt_q;
`ifdef DMEM_ARB_RR_EN
    last_d  = last_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          if (pick) begin
            we_d    = bus.m1_we;
            addr_d  = bus.m1_addr;
            wdata_d = bus.m1_wdata;
          end else begin
            we_d    = bus.m0_we;
            addr_d  = bus.m0_addr;
            wdata_d = bus.m0_wdata;
          end
          gnt_d   = pick;
`ifdef DMEM_ARB_RR_EN
          last_d  = pick;
`endif
          state_d = ISSUE;
        end
      end

      ISSUE: begin
        if (!we_q && (RD_LAT > 1)) begin
          cnt_d   = CNT_INIT;
          state_d = WAIT;
        end else begin
          state_d = RESP;
        end
      end

      WAIT: begin
        if (cnt_q == 3'd0) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end

      RESP: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and capture registers
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      gnt_q   <= 1'b0;
`ifdef DMEM_ARB_RR_EN
      last_q  <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      gnt_q   <= gnt_d;
`ifdef DMEM_ARB_RR_EN
      last_q  <= last_d;
`endif
    end
  end

  // Outputs: everything is forced to zero outside its active cycle so the
  // memory and both requesters see clean idle buses.
  assign in_issue = (state_q == ISSUE);
  assign in_resp  = (state_q == RESP);

  assign bus.mem_en    = in_issue;
  assign bus.mem_we    = in_issue & we_q;
  assign bus.mem_addr  = in_issue ? addr_q  : '0;
  assign bus.mem_wdata = in_issue ? wdata_q : '0;

  assign bus.m0_ack    = in_resp & ~gnt_q;
  assign bus.m1_ack    = in_resp &  gnt_q;

  // Read data is a combinational pass-through; the memory holds it valid
  // during RESP.
  assign bus.m0_rdata  = (in_resp && !gnt_q && !we_q) ? bus.mem_rdata : '0;
  assign bus.m1_rdata  = (in_resp &&  gnt_q && !we_q) ? bus.mem_rdata : '0;

  assign bus.busy      = (state_q != IDLE);
  assign bus.gnt_id    = gnt_q;

endmodule
